// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with leading-zero blanking and optional hex glyphs.
// Optional decimal-point lane is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SEG7_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int unsigned SHADOW_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [6:0]            segment_q, segment_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  tick_c;

  logic [NUM_DIGITS-1:0] lz_zero_c;
  logic                  upper_zero_c;
  logic [3:0]            cur_code_c;
  logic                  cur_blank_c;

`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  dp_q, dp_d;
  logic                  cur_dp_c;
`endif

  // Segment glyph {a,b,c,d,e,f,g}; codes above 9 depend on HEX_MODE.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: begin
        if (HEX_MODE != 0) begin
          case (code)
            4'd10:   seg = 7'b1110111;
            4'd11:   seg = 7'b0011111;
            4'd12:   seg = 7'b1001110;
            4'd13:   seg = 7'b0111101;
            4'd14:   seg = 7'b1001111;
            default: seg = 7'b1000111;
          endcase
        end
      end
    endcase
    return seg;
  endfunction

  // Prescaler and scan index.
  always_comb begin
    tick_c = (pre_q == PRE_W'(REFRESH_DIV - 1));
    pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    idx_d  = idx_q;
    if (tick_c) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Shadow capture.
  always_comb begin
    shadow_d = load ? bcd_in : shadow_q;
`ifdef SEG7_SCAN_DP_EN
    shadow_dp_d = load ? dp_in : shadow_dp_q;
`endif
  end

  // lz_zero_c[i] is set when digits NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    lz_zero_c    = '0;
    upper_zero_c = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero_c = upper_zero_c & (shadow_q[4*i +: 4] == 4'd0);
      lz_zero_c[i] = upper_zero_c;
    end
  end

  // Select the current digit and form the next output word.
  always_comb begin
    cur_code_c  = '0;
    cur_blank_c = 1'b0;
    digit_en_d  = '0;
`ifdef SEG7_SCAN_DP_EN
    cur_dp_c    = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code_c    = shadow_q[4*i +: 4];
        cur_blank_c   = blank_lz && (i != 0) && lz_zero_c[i];
        digit_en_d[i] = 1'b1;
`ifdef SEG7_SCAN_DP_EN
        cur_dp_c      = shadow_dp_q[i];
`endif
      end
    end
    segment_d = cur_blank_c ? 7'b0000000 : decode(cur_code_c);
`ifdef SEG7_SCAN_DP_EN
    dp_d = cur_dp_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      segment_q  <= '0;
      digit_en_q <= '0;
`ifdef SEG7_SCAN_DP_EN
      shadow_dp_q <= '0;
      dp_q        <= 1'b0;
`endif
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      segment_q  <= segment_d;
      digit_en_q <= digit_en_d;
`ifdef SEG7_SCAN_DP_EN
      shadow_dp_q <= shadow_dp_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign segment  = segment_q;
  assign digit_en = digit_en_q;
`ifdef SEG7_SCAN_DP_EN
  assign dp = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus randomized traffic vs. a cycle-count model.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 4;

  localparam logic [6:0] DEC_TAB [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                          7'b1111111, 7'b1111011};
  localparam logic [6:0] HEX_TAB [6]  = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101,
                                          7'b1001111, 7'b1000111};

  logic         clk;
  logic         rst;
  logic [15:0]  bcd_in;
  logic         load;
  logic         blank_lz;
  logic [6:0]   seg_dec, seg_hex;
  logic [3:0]   en_dec, en_hex;
`ifdef SEG7_SCAN_DP_EN
  logic [3:0]   dp_in;
  logic         dp_dec, dp_hex;
  logic [3:0]   m_dp;
  logic         exp_dp;
`endif

  int           n_checks = 0;
  int           n_fail   = 0;

  // Reference model state: edges since reset and the latched value.
  int           m_cyc = 0;
  logic [15:0]  m_val = '0;
  int           m_idx;
  logic [6:0]   exp_seg_dec, exp_seg_hex;
  logic [3:0]   exp_en;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0)) u_dut_dec (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
`ifdef SEG7_SCAN_DP_EN
    .dp_in(dp_in), .dp(dp_dec),
`endif
    .segment(seg_dec), .digit_en(en_dec)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1)) u_dut_hex (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
`ifdef SEG7_SCAN_DP_EN
    .dp_in(dp_in), .dp(dp_hex),
`endif
    .segment(seg_hex), .digit_en(en_hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input int code, input bit hex);
    if (code < 10) return DEC_TAB[code];
    if (!hex) return 7'b1111111;
    return HEX_TAB[code - 10];
  endfunction

  // Output after edge k shows digit (k / R) % N of the value held before that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc       = 0;
      m_val       = '0;
      exp_seg_dec = '0;
      exp_seg_hex = '0;
      exp_en      = '0;
`ifdef SEG7_SCAN_DP_EN
      m_dp   = '0;
      exp_dp = 1'b0;
`endif
    end else begin
      m_idx  = (m_cyc / R) % N;
      exp_en = 4'(1 << m_idx);
      if (blank_lz && m_idx > 0 && (m_val >> (4 * m_idx)) == 16'd0) begin
        exp_seg_dec = '0;
        exp_seg_hex = '0;
      end else begin
        exp_seg_dec = ref_glyph(int'((m_val >> (4 * m_idx)) & 16'hF), 1'b0);
        exp_seg_hex = ref_glyph(int'((m_val >> (4 * m_idx)) & 16'hF), 1'b1);
      end
`ifdef SEG7_SCAN_DP_EN
      exp_dp = m_dp[m_idx];
`endif
      m_cyc = m_cyc + 1;
      if (load) begin
        m_val = bcd_in;
`ifdef SEG7_SCAN_DP_EN
        m_dp = dp_in;
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then load v on the first edge after release (edge k = 0).
  task automatic restart(input logic [15:0] v);
    rst  = 1'b1;
    load = 1'b0;
    step();
    rst    = 1'b0;
    load   = 1'b1;
    bcd_in = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (seg_dec !== 7'b0 || en_dec !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d seg=%b en=%b expected seg=0000000 en=0000", c, seg_dec, en_dec);
      end
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (seg_dec !== 7'b1111110 || en_dec !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release seg=%b en=%b expected seg=1111110 en=0001", seg_dec, en_dec);
    end
  endtask

  task automatic test_full_scan();
    logic [6:0] tab [4];
    int idx;
    tab = '{7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    blank_lz = 1'b0;
    restart(16'h9876);
    for (int k = 1; k <= 20; k++) begin
      step();
      idx = (k / 4) % 4;
      n_checks++;
      if (en_dec !== 4'(1 << idx) || seg_dec !== tab[idx]) begin
        n_fail++;
        $display("FAIL full_scan k=%0d seg=%b en=%b expected seg=%b en=%b", k, seg_dec, en_dec, tab[idx], 4'(1 << idx));
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] tab [4];
    int idx;
    tab = '{7'b1110111, 7'b0111101, 7'b1001111, 7'b1000111};
    blank_lz = 1'b0;
    restart(16'hFEDA);
    for (int k = 1; k <= 16; k++) begin
      step();
      idx = (k / 4) % 4;
      n_checks++;
      if (seg_dec !== 7'b1111111) begin
        n_fail++;
        $display("FAIL hex_off k=%0d seg=%b expected 1111111", k, seg_dec);
      end
      n_checks++;
      if (seg_hex !== tab[idx] || en_hex !== 4'(1 << idx)) begin
        n_fail++;
        $display("FAIL hex_on k=%0d seg=%b en=%b expected seg=%b en=%b", k, seg_hex, en_hex, tab[idx], 4'(1 << idx));
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] pats [3];
    logic [6:0]  exps [3][4];
    int idx;
    pats = '{16'h0042, 16'h0000, 16'h0402};
    exps = '{'{7'b1101101, 7'b0110011, 7'b0000000, 7'b0000000},
             '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000},
             '{7'b1101101, 7'b1111110, 7'b0110011, 7'b0000000}};
    blank_lz = 1'b1;
    for (int p = 0; p < 3; p++) begin
      restart(pats[p]);
      for (int k = 1; k <= 16; k++) begin
        step();
        idx = (k / 4) % 4;
        n_checks++;
        if (seg_dec !== exps[p][idx] || en_dec !== 4'(1 << idx)) begin
          n_fail++;
          $display("FAIL blank val=%h k=%0d seg=%b en=%b expected seg=%b en=%b", pats[p], k, seg_dec, en_dec, exps[p][idx], 4'(1 << idx));
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_midscan_collision();
    blank_lz = 1'b0;
    restart(16'h0000);
    for (int k = 1; k <= 5; k++) step();
    load   = 1'b1;
    bcd_in = 16'h1111;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (seg_dec !== 7'b0110000 || en_dec !== 4'b0010) begin
      n_fail++;
      $display("FAIL midscan_load seg=%b en=%b expected seg=0110000 en=0010", seg_dec, en_dec);
    end
    for (int k = 8; k <= 10; k++) step();
    load   = 1'b1;
    bcd_in = 16'h2222;
    step();
    load = 1'b0;
    n_checks++;
    if (seg_dec !== 7'b0110000 || en_dec !== 4'b0100) begin
      n_fail++;
      $display("FAIL collision_edge seg=%b en=%b expected seg=0110000 en=0100", seg_dec, en_dec);
    end
    step();
    n_checks++;
    if (seg_dec !== 7'b1101101 || en_dec !== 4'b1000) begin
      n_fail++;
      $display("FAIL collision_next seg=%b en=%b expected seg=1101101 en=1000", seg_dec, en_dec);
    end
  endtask

`ifdef SEG7_SCAN_DP_EN
  task automatic test_dp();
    int idx;
    dp_in = 4'b0100;
    restart(16'h1234);
    dp_in = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      step();
      idx = (k / 4) % 4;
      n_checks++;
      if (dp_dec !== (idx == 2) || dp_hex !== (idx == 2)) begin
        n_fail++;
        $display("FAIL dp_scan k=%0d dp=%b/%b expected %b", k, dp_dec, dp_hex, idx == 2);
      end
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (dp_dec !== 1'b0) begin
      n_fail++;
      $display("FAIL dp_reset dp=%b expected 0", dp_dec);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if (dp_dec !== 1'b0) begin
        n_fail++;
        $display("FAIL dp_after_reset k=%0d dp=%b expected 0", k, dp_dec);
      end
    end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      load   = ($urandom_range(0, 3) == 0);
      bcd_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bcd_in = bcd_in & 16'h00FF;
      if ($urandom_range(0, 3) == 0) bcd_in = bcd_in & 16'h0F0F;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
`ifdef SEG7_SCAN_DP_EN
      dp_in = 4'($urandom);
`endif
      step();
      n_checks++;
      if (seg_dec !== exp_seg_dec || en_dec !== exp_en) begin
        n_fail++;
        $display("FAIL rand_dec c=%0d seg=%b en=%b expected seg=%b en=%b", c, seg_dec, en_dec, exp_seg_dec, exp_en);
      end
      n_checks++;
      if (seg_hex !== exp_seg_hex || en_hex !== exp_en) begin
        n_fail++;
        $display("FAIL rand_hex c=%0d seg=%b en=%b expected seg=%b en=%b", c, seg_hex, en_hex, exp_seg_hex, exp_en);
      end
`ifdef SEG7_SCAN_DP_EN
      n_checks++;
      if (dp_dec !== exp_dp || dp_hex !== exp_dp) begin
        n_fail++;
        $display("FAIL rand_dp c=%0d dp=%b/%b expected %b", c, dp_dec, dp_hex, exp_dp);
      end
`endif
    end
    load = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;
`ifdef SEG7_SCAN_DP_EN
    dp_in    = '0;
`endif
    test_reset();
    test_full_scan();
    test_hex();
    test_blanking();
    test_midscan_collision();
`ifdef SEG7_SCAN_DP_EN
    test_dp();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-segment 7-segment display.
- Latches a packed multi-digit BCD/hex word and scans the digits one at a time at a programmable refresh rate.
- Drives one shared registered segment bus plus a one-hot digit enable.
- Adds optional hex glyphs and leading-zero blanking; sits between counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clk cycles each digit is held; legal range >=1; 1 = advance every cycle.
- HEX_MODE, 0, 0 = codes 10..15 show all segments on; 1 = codes 10..15 show A b C d E F.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- bcd_in  input  4*NUM_DIGITS  packed digit codes; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- load  input  1  when high at a clk edge, bcd_in is captured into the shadow register.
- blank_lz  input  1  leading-zero blanking enable.
- segment  output  7  registered segment pattern {a,b,c,d,e,f,g}, a = bit 6, active-high.
- digit_en  output  NUM_DIGITS  registered one-hot digit select, active-high.

Behaviour:
- Reset (rst high at an edge):
  - Prescaler = 0, scan index = 0, shadow = 0.
  - segment = 7'b0000000, digit_en = 0.
  - rst overrides load and tick in the same cycle.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1).
  - Width is $clog2(REFRESH_DIV), minimum 1 bit.
- Scan index:
  - On tick, index advances by 1; NUM_DIGITS-1 wraps to 0.
  - With NUM_DIGITS = 1 the index stays 0.
- Shadow register:
  - Captured on an edge with load = 1.
  - The scan index and prescaler are not disturbed by load.
- Output register: every non-reset edge, segment <= decode(shadow[index]) and digit_en <= one-hot(index).
  - Each output reflects the index and shadow values present before that edge, i.e. one cycle of pipeline latency.
  - Consequences: the index change is visible on outputs one cycle after the tick edge; load data is visible one cycle after the load edge, for the currently selected digit.
  - After reset release, the first edge gives digit_en = 1 (digit 0) and segment = 7'b1111110.
- Decode, codes 0..9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
- Decode, codes 10..15:
  - HEX_MODE = 0: 1111111.
  - HEX_MODE = 1: 1110111 (A), 0011111 (b), 1001110 (C), 0111101 (d), 1001111 (E), 1000111 (F).
- Leading-zero blanking:
  - Digit i is blanked when blank_lz = 1, i > 0, and every digit from NUM_DIGITS-1 down to i has code 0.
  - A blanked digit drives segment = 0000000; digit_en still selects it.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - blank_lz is sampled combinationally each cycle; it is not latched.
- Simultaneous load and tick: both apply at the same edge; the next output uses the new index and the new shadow.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_in [NUM_DIGITS-1:0], captured into the shadow with load.
  - Adds output dp, registered alongside segment; dp = shadow_dp[index] with the same one-cycle latency.
  - dp resets to 0 and is not affected by blanking.
- Undefined: dp_in and dp ports do not exist; no dp logic.

Test Plan:
- Reset: hold rst 3 cycles, then release with REFRESH_DIV=4, NUM_DIGITS=4 -> during rst segment=0000000, digit_en=0000; first edge after release gives digit_en=0001, segment=1111110.
- Full scan: load bcd_in=16'h9876, REFRESH_DIV=4 -> digit_en cycles 0001,0010,0100,1000,0001 every 4 cycles with segment 1011111(6), 1110000(7), 1111111(8), 1111011(9); wrap back to digit 0 confirmed.
- Invalid/hex: load 16'hFEDA with HEX_MODE=0 -> every digit 1111111; with HEX_MODE=1 -> 1110111, 0111101, 1001111, 1000111 for digits 0..3.
- Blanking: load 16'h0042, blank_lz=1 -> digits 3,2 give 0000000, digit 1 gives 0110011, digit 0 gives 1101101; load 16'h0000 -> only digit 0 lit with 1111110; load 16'h0402 -> digit 3 blank, digit 2 shows 0110011, digit 1 shows 1111110 (an embedded zero is not blanked).
- Mid-scan load and collision: while digit 1 is selected, load 16'h1111 -> segment 0110000 on the next edge, index unchanged; assert load on a tick edge -> the next output shows the new digit with the new data.
- SEG7_SCAN_DP_EN: dp_in=4'b0100, load -> dp=1 only while digit_en=0100; dp=0 during and after rst.
